qif_neuron_scheduler: RTL

QIF_NEURON_SCHEDULER -- requirements
Module: qif_neuron_scheduler

---
 rtl/qif_sched_pkg.sv | 15 +
 rtl/qif_state_regfile.sv | 42 ++++
 rtl/qif_neuron_scheduler.sv | 108 ++++++++++
 3 files changed

// File: rtl/qif_sched_pkg.sv
// Shared FSM encoding and default neuron constants for the QIF neuron scheduler.
package qif_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_e;

  localparam logic [7:0] V_THRESH_DEF = 8'd240;
  localparam logic [7:0] V_RESET_DEF  = 8'd0;
  localparam int         TIMEOUT_DEF  = 15;

endpackage

// File: rtl/qif_state_regfile.sv
// Per-neuron membrane (v) and input-current (I) storage: shared read index,
// independent write ports for engine write-back and configuration.
module qif_state_regfile #(
  parameter int             N       = 4,
  parameter int             V_W     = 8,
  parameter int             IW      = $clog2(N),
  parameter logic [V_W-1:0] V_RESET = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IW-1:0]  rd_idx,
  output logic [V_W-1:0] rd_v,
  output logic [V_W-1:0] rd_i,
  input  logic           v_we,
  input  logic [IW-1:0]  v_widx,
  input  logic [V_W-1:0] v_wdata,
  input  logic           i_we,
  input  logic [IW-1:0]  i_widx,
  input  logic [V_W-1:0] i_wdata
);

  logic [V_W-1:0] v_q [N];
  logic [V_W-1:0] i_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        v_q[k] <= V_RESET;
        i_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (v_we && v_widx == IW'(k)) v_q[k] <= v_wdata;
        if (i_we && i_widx == IW'(k)) i_q[k] <= i_wdata;
      end
    end
  end

  assign rd_v = v_q[rd_idx];
  assign rd_i = i_q[rd_idx];

endmodule

// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexes N_NEURONS virtual QIF neurons onto one external update engine,
// round-robin, with write-back threshold/spike handling and an engine watchdog.
module qif_neuron_scheduler
  import qif_sched_pkg::*;
#(
  parameter int             N_NEURONS = 4,
  parameter int             V_W       = 8,
  parameter logic [V_W-1:0] V_THRESH  = V_THRESH_DEF,
  parameter logic [V_W-1:0] V_RESET   = V_RESET_DEF,
  parameter int             TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0]  cfg_addr,
  input  logic [V_W-1:0]                cfg_data,
  output logic                          eng_start,
  output logic [V_W-1:0]                eng_v,
  output logic [V_W-1:0]                eng_i,
  input  logic                          eng_done,
  input  logic [V_W-1:0]                eng_v_next,
  output logic [N_NEURONS-1:0]          spike,
  output logic [V_W-1:0]                v_mon,
  output logic                          busy,
  output logic                          err
);

  localparam int IW = $clog2(N_NEURONS);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e         state, state_nxt;
  logic [IW-1:0]  idx, idx_nxt;
  logic [TW-1:0]  tmo_cnt;
  logic [V_W-1:0] cap, rd_v, rd_i, v_wb;
  logic           tmo, tmo_hit, over, wb_ok;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
  assign over    = (cap >= V_THRESH);
  assign v_wb    = over ? V_RESET : cap;
  assign wb_ok   = (state == S_WB) && !tmo;
  // Operands are latched on entry to ISSUE, so the read port follows the next index.
  assign idx_nxt = (state == S_WB) ? idx + IW'(1) : idx;

  qif_state_regfile #(
    .N(N_NEURONS), .V_W(V_W), .IW(IW), .V_RESET(V_RESET)
  ) u_regfile (
    .clk(clk), .rst_n(rst_n),
    .rd_idx(idx_nxt), .rd_v(rd_v), .rd_i(rd_i),
    .v_we(wb_ok), .v_widx(idx), .v_wdata(v_wb),
    .i_we(cfg_we), .i_widx(cfg_addr), .i_wdata(cfg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ena) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (eng_done || tmo_hit) state_nxt = S_WB;
      S_WB:    state_nxt = ena ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    eng_start = (state == S_ISSUE);
    busy      = (state != S_IDLE);
    spike     = '0;
    if (wb_ok && over) spike[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      tmo_cnt <= '0;
      eng_v   <= '0;
      eng_i   <= '0;
      cap     <= '0;
      tmo     <= 1'b0;
      err     <= 1'b0;
      v_mon   <= '0;
    end else begin
      idx     <= idx_nxt;
      tmo_cnt <= (state == S_WAIT) ? tmo_cnt + TW'(1) : '0;
      if (state_nxt == S_ISSUE) begin
        eng_v <= rd_v;
        eng_i <= rd_i;
      end
      // A result arriving on the last allowed WAIT cycle still wins over the watchdog.
      if (state == S_WAIT) begin
        if (eng_done) begin
          cap <= eng_v_next;
          tmo <= 1'b0;
        end else if (tmo_hit) begin
          tmo <= 1'b1;
          err <= 1'b1;
        end
      end
      if (wb_ok) v_mon <= v_wb;
    end
  end

endmodule
